// File: rtl/mem_arbiter_pkg.sv
// Shared memory-system definitions: block widths, arbiter state encoding and
// client identifiers used by the cache/memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } arb_state_t;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } client_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the instruction
// cache (reads) and the data cache (refills and write-backs).
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                ic_mem_read,
  input  logic [ADDR_W-1:0]   ic_mem_address,
  output logic [DATA_W-1:0]   ic_mem_readdata,
  output logic                ic_mem_busywait,
  input  logic                dc_mem_read,
  input  logic                dc_mem_write,
  input  logic [ADDR_W-1:0]   dc_mem_address,
  input  logic [DATA_W-1:0]   dc_mem_writedata,
  output logic [DATA_W-1:0]   dc_mem_readdata,
  output logic                dc_mem_busywait,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_busywait
);

  arb_state_t state;
  client_t    last_grant;
  logic       launched;
  logic       ic_req;
  logic       dc_req;

  assign ic_req = ic_mem_read;
  assign dc_req = dc_mem_read | dc_mem_write;

  assign ic_mem_busywait = ic_req && (state != DONE_I);
  assign dc_mem_busywait = dc_req && (state != DONE_D);

  // Memory port is a pass-through of the client being served; a dcache
  // request with both read and write set is a write-back.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      SERVE_I: begin
        mem_read    = ic_mem_read;
        mem_address = ic_mem_address;
      end
      SERVE_D: begin
        mem_read      = dc_mem_read & ~dc_mem_write;
        mem_write     = dc_mem_write;
        mem_address   = dc_mem_address;
        mem_writedata = dc_mem_writedata;
      end
      default: ;
    endcase
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      state           <= IDLE;
      launched        <= 1'b0;
      last_grant      <= CLIENT_I;
      ic_mem_readdata <= '0;
      dc_mem_readdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          launched <= 1'b0;
          if (ic_req && (!dc_req || last_grant == CLIENT_D)) begin
            state      <= SERVE_I;
            last_grant <= CLIENT_I;
          end else if (dc_req) begin
            state      <= SERVE_D;
            last_grant <= CLIENT_D;
          end
        end
        // busywait from memory is stale on the first serve cycle, so it is
        // only honoured once launched is set.
        SERVE_I: begin
          if (!ic_req) begin
            state    <= IDLE;
            launched <= 1'b0;
          end else if (!launched) begin
            launched <= 1'b1;
          end else if (!mem_busywait) begin
            ic_mem_readdata <= mem_readdata;
            state           <= DONE_I;
            launched        <= 1'b0;
          end
        end
        SERVE_D: begin
          if (!dc_req) begin
            state    <= IDLE;
            launched <= 1'b0;
          end else if (!launched) begin
            launched <= 1'b1;
          end else if (!mem_busywait) begin
            if (!dc_mem_write) dc_mem_readdata <= mem_readdata;
            state    <= DONE_D;
            launched <= 1'b0;
          end
        end
        DONE_I, DONE_D: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner-case
// sequences and concurrent randomized clients against a behavioural memory.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ic_mem_read = 1'b0;
  logic [27:0]  ic_mem_address = '0;
  logic [127:0] ic_mem_readdata;
  logic         ic_mem_busywait;
  logic         dc_mem_read = 1'b0;
  logic         dc_mem_write = 1'b0;
  logic [27:0]  dc_mem_address = '0;
  logic [127:0] dc_mem_writedata = '0;
  logic [127:0] dc_mem_readdata;
  logic         dc_mem_busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b0;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_mem_read(ic_mem_read), .ic_mem_address(ic_mem_address),
    .ic_mem_readdata(ic_mem_readdata), .ic_mem_busywait(ic_mem_busywait),
    .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
    .dc_mem_address(dc_mem_address), .dc_mem_writedata(dc_mem_writedata),
    .dc_mem_readdata(dc_mem_readdata), .dc_mem_busywait(dc_mem_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural main memory: responds on the rising edge, away from the
  // arbiter's falling edge, after a per-transaction latency.
  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } mlog_t;

  logic [127:0] mem [logic [27:0]];
  logic [127:0] dref [logic [27:0]];
  mlog_t        mlog [$];
  int           fixed_lat = 0;
  int           cnt = 0;
  int           cur_lat = 0;
  bit           active = 0;
  bit           done = 0;

  function automatic logic [127:0] fill(input logic [27:0] a);
    return {4{a, 4'h9}};
  endfunction

  function automatic logic [127:0] mem_get(input logic [27:0] a);
    return mem.exists(a) ? mem[a] : fill(a);
  endfunction

  always @(posedge clock) begin
    if (!(mem_read || mem_write)) begin
      active = 0; done = 0; cnt = 0;
      mem_busywait <= 1'b0;
    end else if (done) begin
      mem_busywait <= 1'b0;
    end else begin
      if (!active) begin
        active  = 1; cnt = 0;
        cur_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
      end
      if (cnt < cur_lat) begin
        cnt++;
        mem_busywait <= 1'b1;
      end else begin
        done = 1;
        mem_busywait <= 1'b0;
        mlog.push_back('{mem_read, mem_write, mem_address, mem_writedata});
        if (mem_write) mem[mem_address] = mem_writedata;
        else mem_readdata <= mem_get(mem_address);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a rising edge; leaves the request asserted so the caller can
  // either drop it or chain straight into the next request.
  task automatic xact(input bit is_dc, input bit rd, input bit wr, input logic [27:0] a,
                      input logic [127:0] wd, output logic [127:0] rdata, output int cycles);
    logic busy;
    if (is_dc) begin
      dc_mem_address = a; dc_mem_writedata = wd; dc_mem_read = rd; dc_mem_write = wr;
    end else begin
      ic_mem_address = a; ic_mem_read = 1'b1;
    end
    cycles = 0;
    busy   = 1'b1;
    while (busy && cycles < 100) begin
      @(posedge clock);
      cycles++;
      busy = is_dc ? dc_mem_busywait : ic_mem_busywait;
    end
    chki(is_dc ? "dc_busywait_release" : "ic_busywait_release", int'(busy), 0);
    rdata = is_dc ? dc_mem_readdata : ic_mem_readdata;
  endtask

  task automatic drop(input bit is_dc);
    if (is_dc) begin dc_mem_read = 1'b0; dc_mem_write = 1'b0; end
    else ic_mem_read = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    bit           is_dc;
    bit           rd;
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wd;
    int           lat;
    bit           exp_rd;
    bit           exp_wr;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t         vt [7];
  logic [127:0] exp_ic = '0;
  logic [127:0] exp_dc = '0;

  initial begin
    logic [127:0] r, r_i, r_d;
    int           c, c_i, c_d, n0, exp_cyc;

    mem[28'h10] = {16{8'hA5}};
    mem[28'h50] = {16{8'h5C}};
    mem[28'h70] = {4{32'hDEADBEEF}};
    vt[0] = '{0, 1, 0, 28'h10, '0,             3, 1, 0, {16{8'hA5}}};
    vt[1] = '{1, 0, 1, 28'h40, {16{8'h11}},    2, 0, 1, '0};
    vt[2] = '{1, 1, 0, 28'h50, '0,             1, 1, 0, {16{8'h5C}}};
    vt[3] = '{1, 1, 1, 28'h60, {16{8'h22}},    0, 0, 1, {16{8'h5C}}};
    vt[4] = '{1, 1, 0, 28'h40, '0,             0, 1, 0, {16{8'h11}}};
    vt[5] = '{0, 1, 0, 28'h60, '0,             2, 1, 0, {16{8'h22}}};
    vt[6] = '{0, 1, 0, 28'h70, '0,             4, 1, 0, {4{32'hDEADBEEF}}};

    repeat (3) @(posedge clock);
    reset = 1'b0;
    @(posedge clock);
    chk("rst_ic_readdata", ic_mem_readdata, '0);
    chk("rst_dc_readdata", dc_mem_readdata, '0);
    chki("rst_mem_read", int'(mem_read), 0);
    chki("rst_mem_write", int'(mem_write), 0);
    chk("rst_mem_address", 128'(mem_address), '0);
    chk("rst_mem_writedata", mem_writedata, '0);
    chki("rst_ic_busywait", int'(ic_mem_busywait), 0);
    chki("rst_dc_busywait", int'(dc_mem_busywait), 0);

    foreach (vt[i]) begin
      fixed_lat = vt[i].lat;
      n0 = mlog.size();
      xact(vt[i].is_dc, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, r, c);
      drop(vt[i].is_dc);
      if (vt[i].is_dc) exp_dc = vt[i].exp_rdata; else exp_ic = vt[i].exp_rdata;
      exp_cyc = (vt[i].lat + 2 > 3) ? vt[i].lat + 2 : 3;
      chk($sformatf("vec%0d_rdata", i), r, vt[i].exp_rdata);
      chki($sformatf("vec%0d_latency", i), c, exp_cyc);
      chki($sformatf("vec%0d_mem_txns", i), mlog.size(), n0 + 1);
      if (mlog.size() == n0 + 1) begin
        chki($sformatf("vec%0d_mem_read", i), int'(mlog[n0].rd), int'(vt[i].exp_rd));
        chki($sformatf("vec%0d_mem_write", i), int'(mlog[n0].wr), int'(vt[i].exp_wr));
        chk($sformatf("vec%0d_mem_address", i), 128'(mlog[n0].addr), 128'(vt[i].addr));
        if (vt[i].exp_wr) chk($sformatf("vec%0d_mem_writedata", i), mlog[n0].data, vt[i].wd);
      end
      chk($sformatf("vec%0d_ic_hold", i), ic_mem_readdata, exp_ic);
      chk($sformatf("vec%0d_dc_hold", i), dc_mem_readdata, exp_dc);
      repeat (2) @(posedge clock);
      chki($sformatf("vec%0d_idle_mem_read", i), int'(mem_read | mem_write), 0);
    end

    // Simultaneous requests right after reset: dcache wins first.
    do_reset();
    exp_ic = '0; exp_dc = '0;
    fixed_lat = 1;
    n0 = mlog.size();
    fork
      begin xact(0, 1, 0, 28'h20, '0, r_i, c_i); drop(0); end
      begin xact(1, 1, 0, 28'h30, '0, r_d, c_d); drop(1); end
    join
    chk("both_ic_rdata", r_i, fill(28'h20));
    chk("both_dc_rdata", r_d, fill(28'h30));
    chki("both_txns", mlog.size(), n0 + 2);
    if (mlog.size() >= n0 + 2) begin
      chk("both_first_grant", 128'(mlog[n0].addr), 128'(28'h30));
      chk("both_second_grant", 128'(mlog[n0 + 1].addr), 128'(28'h20));
    end
    repeat (2) @(posedge clock);

    // Both clients hold requests back to back: grants alternate D,I,D,I...
    fixed_lat = 0;
    n0 = mlog.size();
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          xact(0, 1, 0, 28'h80 + 28'(k), '0, r_i, c_i);
          chk($sformatf("alt_ic%0d_rdata", k), r_i, fill(28'h80 + 28'(k)));
        end
        drop(0);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          xact(1, 1, 0, 28'h90 + 28'(k), '0, r_d, c_d);
          chk($sformatf("alt_dc%0d_rdata", k), r_d, fill(28'h90 + 28'(k)));
        end
        drop(1);
      end
    join
    exp_ic = fill(28'h83); exp_dc = fill(28'h93);
    chki("alt_txns", mlog.size(), n0 + 8);
    if (mlog.size() >= n0 + 8) begin
      chki("alt_first_is_dc", int'(mlog[n0].addr[4]), 1);
      for (int k = 1; k < 8; k++)
        chki($sformatf("alt_grant%0d", k), int'(mlog[n0 + k].addr[4]),
             int'(!mlog[n0 + k - 1].addr[4]));
    end
    repeat (2) @(posedge clock);

    // Request dropped mid-serve: abort without touching readdata.
    fixed_lat = 10;
    n0 = mlog.size();
    dc_mem_address = 28'hA0; dc_mem_read = 1'b1;
    repeat (3) @(posedge clock);
    chki("abort_serving", int'(mem_read), 1);
    dc_mem_read = 1'b0;
    repeat (2) @(posedge clock);
    chki("abort_mem_read", int'(mem_read), 0);
    chki("abort_no_txn", mlog.size(), n0);
    chk("abort_dc_hold", dc_mem_readdata, exp_dc);
    chki("abort_dc_busywait", int'(dc_mem_busywait), 0);

    // Reset during a dcache refill.
    dc_mem_address = 28'hB0; dc_mem_read = 1'b1;
    repeat (3) @(posedge clock);
    chki("rstmid_serving", int'(mem_read), 1);
    reset = 1'b1;
    @(posedge clock);
    reset = 1'b0;
    chki("rstmid_mem_read", int'(mem_read), 0);
    chki("rstmid_mem_write", int'(mem_write), 0);
    chk("rstmid_dc_readdata", dc_mem_readdata, '0);
    chk("rstmid_ic_readdata", ic_mem_readdata, '0);
    chki("rstmid_no_txn", mlog.size(), n0);
    drop(1);
    exp_ic = '0; exp_dc = '0;
    repeat (2) @(posedge clock);

    // Randomized concurrent traffic with random memory latency.
    fixed_lat = -1;
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          logic [27:0] a;
          a = 28'h100 + 28'($urandom_range(0, 7));
          xact(0, 1, 0, a, '0, r_i, c_i);
          chk($sformatf("rnd_ic%0d_rdata", k), r_i, fill(a));
          c_i = $urandom_range(0, 2);
          if (c_i > 0) begin drop(0); repeat (c_i) @(posedge clock); end
        end
        drop(0);
      end
      begin
        for (int k = 0; k < 16; k++) begin
          logic [27:0]  a;
          logic [127:0] wd, expd;
          int           op;
          a    = 28'h200 + 28'($urandom_range(0, 7));
          wd   = {$urandom, $urandom, $urandom, $urandom};
          op   = $urandom_range(0, 3);
          expd = dref.exists(a) ? dref[a] : fill(a);
          xact(1, op != 2, op >= 2, a, wd, r_d, c_d);
          if (op >= 2) begin
            dref[a] = wd;
            chk($sformatf("rnd_dc%0d_memwr", k), mem_get(a), wd);
            chk($sformatf("rnd_dc%0d_hold", k), r_d, exp_dc);
          end else begin
            exp_dc = expd;
            chk($sformatf("rnd_dc%0d_rdata", k), r_d, expd);
          end
          c_d = $urandom_range(0, 2);
          if (c_d > 0) begin drop(1); repeat (c_d) @(posedge clock); end
        end
        drop(1);
      end
    join
    repeat (3) @(posedge clock);
    chki("end_idle_mem", int'(mem_read | mem_write), 0);
    chk("end_mem_address", 128'(mem_address), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
